// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle shift-and-add multiplier. It borrows the shared datapath ALU,
// issuing one ADD per granted step, and returns the low WIDTH bits of op_a*op_b.
// Optional build macro: MUL_EARLY_EXIT_EN. When it is defined, the operation finishes as
// soon as no set multiplier bits remain. When it is undefined, every operation takes
// WIDTH granted steps.

`ifndef ALUOP_ADD
`define ALUOP_ADD 3'b000
`endif

module alu_mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] acc_step;
  logic             last_step;

  // Per-step accumulator value and final-step detection.
  always_comb begin
    // The ALU adds the shifted multiplicand; keep the sum only when this multiplier bit is set.
    acc_step = mplier_q[0] ? alu_result : acc_q;
`ifdef MUL_EARLY_EXIT_EN
    // Finish early once every remaining multiplier bit is zero.
    last_step = (cnt_q == LastCnt) || ((mplier_q >> 1) == '0);
`else
    last_step = (cnt_q == LastCnt);
`endif
  end

  // Next-state logic: accept start in idle, advance one step per ALU grant in run.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Also taken in the done cycle, so back-to-back operations need no gap.
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Without a grant the ALU result belongs to someone else, so everything holds.
        if (alu_gnt) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_step) begin
            product_d = acc_step;
            done_d    = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  // Outputs are driven straight from registers so the ALU operands are glitch-free.
  always_comb begin
    busy    = (state_q == StRun);
    alu_req = (state_q == StRun);
    alu_a   = acc_q;
    alu_b   = mcand_q;
    alu_op  = `ALUOP_ADD;
    done    = done_q;
    product = product_q;
  end

endmodule
